// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and limits for the data-memory responder
// Purpose: FSM state encoding and latency ceiling used by dmem_responder.
// Ports: none (package).
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int MAX_LATENCY = 15;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage for the data-memory responder
// Purpose: DEPTH_WORDS x 32 array, synchronous write, asynchronous read,
//          synchronous clear of every word while reset is high.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   i_we        write enable for the word at i_addr
//   i_addr      word index (shared by read and write)
//   i_wdata     write data
//   o_rdata     combinational read of the word at i_addr
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_BITS   = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [31:0]          i_wdata,
  output logic [31:0]          o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Read is taken before the same-edge write lands, so a load sees the old word.
  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding word load/store responder
// Purpose: accepts one load/store at a time, performs it on the internal
//          array at acceptance, and presents the response LATENCY edges later.
// Optional feature: DMEM_BOUNDS_CHECK_EN flags addresses above the array as
//          errors; without it upper address bits are ignored (wrap).
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_we, req_addr, req_wdata    store enable, byte address, store data
//   req_rd                         destination tag, echoed on rsp_rd
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata, rsp_rd, rsp_err     load data (0 for stores/errors), tag, error
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [4:0]  rsp_rd,
  output logic        rsp_err
);

  localparam int ADDR_BITS = $clog2(DEPTH_WORDS);
  localparam int CNT_W     = $clog2(LATENCY + 1);

  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("dmem_responder: LATENCY out of range");
  end
  if (DEPTH_WORDS < 2 || DEPTH_WORDS > 4096 || (1 << ADDR_BITS) != DEPTH_WORDS) begin : g_bad_depth
    $error("dmem_responder: DEPTH_WORDS must be a power of two in 2..4096");
  end

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_rsp_valid;
  logic [31:0]        r_rsp_rdata;
  logic [4:0]         r_rsp_rd;
  logic               r_rsp_err;

  logic [ADDR_BITS-1:0] w_idx;
  logic                 w_misaligned;
  logic                 w_oor;
  logic                 w_err;
  logic                 w_accept;
  logic                 w_we;
  logic [31:0]          w_rdata;

  assign w_idx        = req_addr[ADDR_BITS+1:2];
  assign w_misaligned = |req_addr[1:0];

`ifdef DMEM_BOUNDS_CHECK_EN
  assign w_oor = |req_addr[31:ADDR_BITS+2];
`else
  // Upper bits are deliberately dropped so addresses wrap around the array.
  logic w_unused_upper;
  assign w_unused_upper = ^req_addr[31:ADDR_BITS+2];
  assign w_oor          = 1'b0;
`endif

  assign w_err     = w_misaligned | w_oor;
  assign req_ready = (r_state == IDLE);
  assign w_accept  = req_ready & req_valid;
  assign w_we      = w_accept & req_we & ~w_err;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_BITS   (ADDR_BITS)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_addr  (w_idx),
    .i_wdata (req_wdata),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_rd    <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      // Registered copy of the RESP decode so rsp_valid leaves a flop directly.
      r_rsp_valid <= (w_state_nxt == RESP);
      if (w_accept) begin
        r_rsp_rdata <= (req_we || w_err) ? 32'd0 : w_rdata;
        r_rsp_rd    <= req_rd;
        r_rsp_err   <= w_err;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_rd    = r_rsp_rd;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  // Main instance, LATENCY=2
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;

  // LATENCY=1 instance
  logic        l1_req_valid, l1_req_ready, l1_rsp_valid, l1_rsp_ready, l1_rsp_err;
  logic [31:0] l1_rsp_rdata;
  logic [4:0]  l1_rsp_rd;

  // LATENCY=15 instance
  logic        l15_req_valid, l15_req_ready, l15_rsp_valid, l15_rsp_ready, l15_rsp_err;
  logic [31:0] l15_rsp_rdata;
  logic [4:0]  l15_rsp_rd;

  int checks   = 0;
  int failures = 0;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_rd(rsp_rd), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset),
    .req_valid(l1_req_valid), .req_ready(l1_req_ready), .req_we(1'b0),
    .req_addr(32'h0000_0008), .req_wdata(32'h0), .req_rd(5'd11),
    .rsp_valid(l1_rsp_valid), .rsp_ready(l1_rsp_ready), .rsp_rdata(l1_rsp_rdata),
    .rsp_rd(l1_rsp_rd), .rsp_err(l1_rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(15)) u_l15 (
    .clk(clk), .reset(reset),
    .req_valid(l15_req_valid), .req_ready(l15_req_ready), .req_we(1'b0),
    .req_addr(32'h0000_000C), .req_wdata(32'h0), .req_rd(5'd22),
    .rsp_valid(l15_rsp_valid), .rsp_ready(l15_rsp_ready), .rsp_rdata(l15_rsp_rdata),
    .rsp_rd(l15_rsp_rd), .rsp_err(l15_rsp_err)
  );

  // Presents one request on the main instance; returns at the negedge after acceptance.
  task automatic accept(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_timeout req_ready=%b required=1", req_ready);
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_rd = rd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Counts edges after acceptance until rsp_valid, captures, then handshakes.
  task automatic wait_rsp(output int lat, output logic [31:0] rdata, output logic [4:0] rd,
                          output logic err);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (rsp_valid !== 1'b1) lat = -1;
    rdata = rsp_rdata; rd = rsp_rd; err = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [4:0] rd, output int lat, output logic [31:0] rdata,
                      output logic [4:0] rrd, output logic err);
    accept(we, addr, wdata, rd);
    wait_rsp(lat, rdata, rrd, err);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_err} !== 3'b100) begin
      failures++;
      $display("FAIL reset_flags ready/valid/err=%b required=100", {req_ready, rsp_valid, rsp_err});
    end
    checks++;
    if (rsp_rdata !== 32'h0 || rsp_rd !== 5'd0) begin
      failures++;
      $display("FAIL reset_rsp rdata=%h rd=%0d required 0/0", rsp_rdata, rsp_rd);
    end
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] d; logic [4:0] rd; logic e;
    xact(1'b1, 32'h10, 32'hDEADBEEF, 5'd3, lat, d, rd, e);
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL store_latency edges=%0d required=1", lat);
    end
    checks++;
    if (d !== 32'h0 || rd !== 5'd3 || e !== 1'b0) begin
      failures++;
      $display("FAIL store_rsp rdata=%h rd=%0d err=%b required 0/3/0", d, rd, e);
    end
    xact(1'b0, 32'h10, 32'h0, 5'd7, lat, d, rd, e);
    checks++;
    if (d !== 32'hDEADBEEF || rd !== 5'd7 || e !== 1'b0 || lat !== 1) begin
      failures++;
      $display("FAIL load_rsp rdata=%h rd=%0d err=%b lat=%0d required deadbeef/7/0/1", d, rd, e, lat);
    end
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] d; logic [4:0] rd; logic e;
    xact(1'b1, 32'h13, 32'h12345678, 5'd4, lat, d, rd, e);
    checks++;
    if (e !== 1'b1 || d !== 32'h0 || rd !== 5'd4 || lat !== 1) begin
      failures++;
      $display("FAIL misaligned_store err=%b rdata=%h rd=%0d lat=%0d required 1/0/4/1", e, d, rd, lat);
    end
    xact(1'b0, 32'h10, 32'h0, 5'd8, lat, d, rd, e);
    checks++;
    if (d !== 32'hDEADBEEF || e !== 1'b0) begin
      failures++;
      $display("FAIL misaligned_no_write rdata=%h err=%b required deadbeef/0", d, e);
    end
    xact(1'b0, 32'h12, 32'h0, 5'd9, lat, d, rd, e);
    checks++;
    if (e !== 1'b1 || d !== 32'h0 || rd !== 5'd9) begin
      failures++;
      $display("FAIL misaligned_load err=%b rdata=%h rd=%0d required 1/0/9", e, d, rd);
    end
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] d; logic [4:0] rd; logic e;
    logic [31:0] exp_d; logic exp_e; logic [31:0] exp_w1;
`ifdef DMEM_BOUNDS_CHECK_EN
    exp_d = 32'h0; exp_e = 1'b1; exp_w1 = 32'h0;
`else
    exp_d = 32'hA5A50001; exp_e = 1'b0; exp_w1 = 32'h0BADF00D;
`endif
    xact(1'b1, 32'h0, 32'hA5A50001, 5'd1, lat, d, rd, e);
    xact(1'b0, 32'h400, 32'h0, 5'd10, lat, d, rd, e);
    checks++;
    if (d !== exp_d || e !== exp_e || rd !== 5'd10) begin
      failures++;
      $display("FAIL oor_load rdata=%h err=%b rd=%0d required %h/%b/10", d, e, rd, exp_d, exp_e);
    end
    xact(1'b1, 32'h404, 32'h0BADF00D, 5'd2, lat, d, rd, e);
    checks++;
    if (e !== exp_e || d !== 32'h0) begin
      failures++;
      $display("FAIL oor_store err=%b rdata=%h required %b/0", e, d, exp_e);
    end
    xact(1'b0, 32'h4, 32'h0, 5'd12, lat, d, rd, e);
    checks++;
    if (d !== exp_w1 || e !== 1'b0) begin
      failures++;
      $display("FAIL oor_word1 rdata=%h err=%b required %h/0", d, e, exp_w1);
    end
  endtask

  task automatic test_backpressure();
    int n; logic [31:0] d; logic [4:0] rd; logic e; int lat;
    accept(1'b0, 32'h10, 32'h0, 5'd5);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_rsp_valid rsp_valid=%b required=1", rsp_valid);
    end
    // Competing store presented while the response is stalled.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h11111111; req_rd = 5'd6;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || rsp_rd !== 5'd5 ||
          rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d valid=%b rdata=%h rd=%0d err=%b ready=%b required 1/deadbeef/5/0/0",
                 i, rsp_valid, rsp_rdata, rsp_rd, rsp_err, req_ready);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release valid=%b ready=%b required 0/1", rsp_valid, req_ready);
    end
    xact(1'b0, 32'h10, 32'h0, 5'd13, lat, d, rd, e);
    checks++;
    if (d !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL bp_no_accept rdata=%h required deadbeef", d);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] d; logic [4:0] rd; logic e; int seen;
    xact(1'b1, 32'h20, 32'h00000077, 5'd14, lat, d, rd, e);
    accept(1'b0, 32'h20, 32'h0, 5'd15);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_discard valid_cycles=%0d ready=%b required 0/1", seen, req_ready);
    end
    xact(1'b0, 32'h20, 32'h0, 5'd16, lat, d, rd, e);
    checks++;
    if (d !== 32'h0 || rd !== 5'd16) begin
      failures++;
      $display("FAIL reset_mid_clear20 rdata=%h rd=%0d required 0/16", d, rd);
    end
    xact(1'b0, 32'h10, 32'h0, 5'd17, lat, d, rd, e);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_clear10 rdata=%h required 0", d);
    end
  endtask

  task automatic test_latency_sweep();
    int n;
    @(negedge clk);
    l1_req_valid = 1'b1;
    l15_req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    l1_req_valid = 1'b0;
    l15_req_valid = 1'b0;
    checks++;
    if (l1_rsp_valid !== 1'b1 || l1_rsp_rd !== 5'd11 || l1_rsp_rdata !== 32'h0 || l1_rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL lat1 valid=%b rd=%0d rdata=%h err=%b required 1/11/0/0",
               l1_rsp_valid, l1_rsp_rd, l1_rsp_rdata, l1_rsp_err);
    end
    l1_rsp_ready = 1'b1;
    n = 0;
    while (l15_rsp_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    l1_rsp_ready = 1'b0;
    checks++;
    if (n !== 14 || l15_rsp_rd !== 5'd22 || l15_rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL lat15 edges=%0d rd=%0d err=%b required 14/22/0", n, l15_rsp_rd, l15_rsp_err);
    end
    l15_rsp_ready = 1'b1;
    @(negedge clk);
    l15_rsp_ready = 1'b0;
    checks++;
    if (l15_req_ready !== 1'b1 || l1_req_ready !== 1'b1 || l1_rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL lat_release l15_ready=%b l1_ready=%b l1_valid=%b required 1/1/0",
               l15_req_ready, l1_req_ready, l1_rsp_valid);
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_rd = '0; rsp_ready = 1'b0;
    l1_req_valid = 1'b0; l1_rsp_ready = 1'b0;
    l15_req_valid = 1'b0; l15_rsp_ready = 1'b0;
    test_reset();
    test_store_load();
    test_misaligned();
    test_out_of_range();
    test_backpressure();
    test_reset_mid();
    test_latency_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
